// File: rtl/wb_ram_bist_pkg.sv
// Shared types and encodings for the Wishbone RAM BIST master.
// Holds FSM states, error codes and run-mode encodings.
package wb_ram_bist_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_WR_REQ,
        S_WR_GAP,
        S_RD_REQ,
        S_RD_GAP,
        S_FINISH
    } state_t;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_MISMATCH = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
    localparam logic [1:0] ERR_ABORT    = 2'd3;

    localparam logic [1:0] MODE_NOP         = 2'd0;
    localparam logic [1:0] MODE_FILL        = 2'd1;
    localparam logic [1:0] MODE_VERIFY      = 2'd2;
    localparam logic [1:0] MODE_FILL_VERIFY = 2'd3;

endpackage

// File: rtl/wb_single_xfer.sv
// One Wishbone classic single transfer with an ack timeout.
// Ports: clk/rst_n; req/we/adr/dat request in; ack_i/rdat_i from
// responder; cyc/stb/we/sel/adr/dat bus out; done_o (acked),
// timeout_o (no ack within TIMEOUT_CYCLES), rdata_o read data.
module wb_single_xfer #(
    parameter int ADDR_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] adr,
    input  logic [31:0]           dat,
    input  logic                  ack_i,
    input  logic [31:0]           rdat_i,
    output logic                  cyc_o,
    output logic                  stb_o,
    output logic                  we_o,
    output logic [3:0]            sel_o,
    output logic [ADDR_WIDTH-1:0] adr_o,
    output logic [31:0]           dat_o,
    output logic                  done_o,
    output logic                  timeout_o,
    output logic [31:0]           rdata_o
);

    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q;

    // Counter is zero on the first cycle of every request because the
    // controller always spends at least one cycle with req low between them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (!req || ack_i) begin
            cnt_q <= '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign cyc_o     = req;
    assign stb_o     = req;
    assign we_o      = req & we;
    assign sel_o     = req ? 4'hF : 4'h0;
    assign adr_o     = req ? adr : '0;
    assign dat_o     = (req && we) ? dat : '0;
    assign done_o    = req & ack_i;
    assign timeout_o = req & ~ack_i & (cnt_q == CNT_MAX);
    assign rdata_o   = rdat_i;

endmodule

// File: rtl/wb_ram_bist_master.sv
// Wishbone RAM BIST master: fills and/or verifies an address range with
// data(a) = pat ^ a, reporting pass, first error code/address/data.
// Ports: start/abort/cfg_* control in; busy/done/pass/err_* status out;
// wbm_* Wishbone classic initiator port.
module wb_ram_bist_master
    import wb_ram_bist_pkg::*;
#(
    parameter int ADDR_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_n_i,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic [1:0]            cfg_mode_i,
    input  logic [ADDR_WIDTH-1:0] cfg_base_i,
    input  logic [ADDR_WIDTH-1:0] cfg_last_i,
    input  logic [31:0]           cfg_pat_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  pass_o,
    output logic [1:0]            err_code_o,
    output logic [ADDR_WIDTH-1:0] err_addr_o,
    output logic [31:0]           err_data_o,
    output logic                  wbm_cyc_o,
    output logic                  wbm_stb_o,
    output logic                  wbm_we_o,
    output logic [3:0]            wbm_sel_o,
    output logic [ADDR_WIDTH-1:0] wbm_adr_o,
    output logic [31:0]           wbm_dat_o,
    input  logic                  wbm_ack_i,
    input  logic [31:0]           wbm_dat_i
);

    state_t state_q, state_d;

    logic [1:0]            mode_q;
    logic [ADDR_WIDTH-1:0] base_q, last_q, cur_q;
    logic [31:0]           pat_q;
    logic [1:0]            err_code_q;
    logic [ADDR_WIDTH-1:0] err_addr_q;
    logic [31:0]           err_data_q;
    logic                  pass_q;

    logic        req, we;
    logic        err_set, err_is_data;
    logic [1:0]  err_nx;
    logic        addr_inc, addr_rewind;
    logic        xfer_done, xfer_to;
    logic [31:0] xfer_rdata;
    logic [31:0] exp_data;
    logic        at_last, start_acc, abortable;

    assign exp_data  = pat_q ^ 32'(cur_q);
    assign at_last   = (cur_q == last_q);
    assign start_acc = (state_q == S_IDLE) && start_i;
    assign abortable = (state_q != S_IDLE) && (state_q != S_FINISH);

    wb_single_xfer #(
        .ADDR_WIDTH    (ADDR_WIDTH),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_xfer (
        .clk      (wb_clk_i),
        .rst_n    (wb_rst_n_i),
        .req      (req),
        .we       (we),
        .adr      (cur_q),
        .dat      (exp_data),
        .ack_i    (wbm_ack_i),
        .rdat_i   (wbm_dat_i),
        .cyc_o    (wbm_cyc_o),
        .stb_o    (wbm_stb_o),
        .we_o     (wbm_we_o),
        .sel_o    (wbm_sel_o),
        .adr_o    (wbm_adr_o),
        .dat_o    (wbm_dat_o),
        .done_o   (xfer_done),
        .timeout_o(xfer_to),
        .rdata_o  (xfer_rdata)
    );

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        req         = 1'b0;
        we          = 1'b0;
        err_set     = 1'b0;
        err_nx      = ERR_NONE;
        err_is_data = 1'b0;
        addr_inc    = 1'b0;
        addr_rewind = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) state_d = S_SETUP;
            end
            S_SETUP: begin
                if (last_q < base_q) begin
                    state_d = S_FINISH;
                    err_set = 1'b1;
                    err_nx  = ERR_ABORT;
                end else begin
                    case (mode_q)
                        MODE_FILL,
                        MODE_FILL_VERIFY: state_d = S_WR_REQ;
                        MODE_VERIFY:      state_d = S_RD_REQ;
                        default:          state_d = S_FINISH;
                    endcase
                end
            end
            S_WR_REQ: begin
                req = 1'b1;
                we  = 1'b1;
                if (xfer_done) begin
                    state_d = S_WR_GAP;
                end else if (xfer_to) begin
                    state_d = S_FINISH;
                    err_set = 1'b1;
                    err_nx  = ERR_TIMEOUT;
                end
            end
            S_WR_GAP: begin
                if (!at_last) begin
                    addr_inc = 1'b1;
                    state_d  = S_WR_REQ;
                end else if (mode_q == MODE_FILL_VERIFY) begin
                    addr_rewind = 1'b1;
                    state_d     = S_RD_REQ;
                end else begin
                    state_d = S_FINISH;
                end
            end
            S_RD_REQ: begin
                req = 1'b1;
                if (xfer_done) begin
                    if (xfer_rdata != exp_data) begin
                        state_d     = S_FINISH;
                        err_set     = 1'b1;
                        err_nx      = ERR_MISMATCH;
                        err_is_data = 1'b1;
                    end else begin
                        state_d = S_RD_GAP;
                    end
                end else if (xfer_to) begin
                    state_d = S_FINISH;
                    err_set = 1'b1;
                    err_nx  = ERR_TIMEOUT;
                end
            end
            S_RD_GAP: begin
                if (at_last) begin
                    state_d = S_FINISH;
                end else begin
                    addr_inc = 1'b1;
                    state_d  = S_RD_REQ;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        // Abort wins over anything else, including an ack in this cycle.
        if (abort_i && abortable) begin
            state_d     = S_FINISH;
            err_set     = 1'b1;
            err_nx      = ERR_ABORT;
            err_is_data = 1'b0;
            addr_inc    = 1'b0;
            addr_rewind = 1'b0;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            mode_q     <= MODE_NOP;
            base_q     <= '0;
            last_q     <= '0;
            cur_q      <= '0;
            pat_q      <= '0;
            err_code_q <= ERR_NONE;
            err_addr_q <= '0;
            err_data_q <= '0;
            pass_q     <= 1'b0;
        end else if (start_acc) begin
            mode_q     <= cfg_mode_i;
            base_q     <= cfg_base_i;
            last_q     <= cfg_last_i;
            pat_q      <= cfg_pat_i;
            cur_q      <= cfg_base_i;
            err_code_q <= ERR_NONE;
            err_addr_q <= '0;
            err_data_q <= '0;
            pass_q     <= 1'b0;
        end else begin
            if (addr_rewind) begin
                cur_q <= base_q;
            end else if (addr_inc) begin
                cur_q <= cur_q + ADDR_WIDTH'(1);
            end
            if (err_set) begin
                err_code_q <= err_nx;
                err_addr_q <= cur_q;
                err_data_q <= err_is_data ? xfer_rdata : '0;
            end
            if (state_q == S_FINISH) begin
                pass_q <= (err_code_q == ERR_NONE);
            end
        end
    end

    // Pass is visible together with the done pulse, then held.
    assign pass_o     = (state_q == S_FINISH) ? (err_code_q == ERR_NONE)
                                              : pass_q;
    assign busy_o     = (state_q != S_IDLE);
    assign done_o     = (state_q == S_FINISH);
    assign err_code_o = err_code_q;
    assign err_addr_o = err_addr_q;
    assign err_data_o = err_data_q;

endmodule

// File: tb/tb_wb_ram_bist_master.sv
// Directed bench for wb_ram_bist_master with a 1-cycle ack RAM model.
// Expected run results are queued at start and compared at done.
module tb_wb_ram_bist_master;
    import wb_ram_bist_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, abort;
    logic [1:0]  cfg_mode;
    logic [7:0]  cfg_base, cfg_last;
    logic [31:0] cfg_pat;
    logic        busy, done, pass;
    logic [1:0]  err_code;
    logic [7:0]  err_addr;
    logic [31:0] err_data;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [7:0]  adr;
    logic [31:0] dat_w, dat_r;
    logic        ack;

    always #5 clk = ~clk;

    wb_ram_bist_master #(
        .ADDR_WIDTH    (8),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_n_i(rst_n),
        .start_i   (start),
        .abort_i   (abort),
        .cfg_mode_i(cfg_mode),
        .cfg_base_i(cfg_base),
        .cfg_last_i(cfg_last),
        .cfg_pat_i (cfg_pat),
        .busy_o    (busy),
        .done_o    (done),
        .pass_o    (pass),
        .err_code_o(err_code),
        .err_addr_o(err_addr),
        .err_data_o(err_data),
        .wbm_cyc_o (cyc),
        .wbm_stb_o (stb),
        .wbm_we_o  (we),
        .wbm_sel_o (sel),
        .wbm_adr_o (adr),
        .wbm_dat_o (dat_w),
        .wbm_ack_i (ack),
        .wbm_dat_i (dat_r)
    );

    // Responder: registered ack, optional hung address, optional bad word.
    logic [31:0] mem [0:255];
    logic        hang_en = 1'b0;
    logic [7:0]  hang_adr = 8'h05;
    logic        bad_en = 1'b0;
    logic [7:0]  bad_adr = 8'h10;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack   <= 1'b0;
            dat_r <= 32'h0;
        end else if (cyc && stb && !ack && !(hang_en && adr == hang_adr)) begin
            ack <= 1'b1;
            if (we) mem[adr] <= dat_w;
            else dat_r <= (bad_en && adr == bad_adr) ? 32'h0 : mem[adr];
        end else begin
            ack <= 1'b0;
        end
    end

    int n_wr = 0, n_rd = 0, n_cyc = 0, n_hang = 0;

    always @(negedge clk) begin
        if (cyc && stb && ack) begin
            if (we) n_wr++;
            else n_rd++;
        end
        if (cyc) n_cyc++;
        if (cyc && hang_en && adr == hang_adr) n_hang++;
    end

    typedef struct {
        logic [1:0]  code;
        logic [7:0]  addr;
        logic [31:0] data;
        logic        pass;
        int          nwr;
        int          nrd;
    } exp_t;

    exp_t sbq[$];
    int   wr0, rd0;
    int   checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_run(input logic [1:0] m, input logic [7:0] b,
                             input logic [7:0] l, input logic [31:0] p,
                             input exp_t e);
        cfg_mode = m;
        cfg_base = b;
        cfg_last = l;
        cfg_pat  = p;
        sbq.push_back(e);
        wr0 = n_wr;
        rd0 = n_rd;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic finish_run(input string tag, input int budget);
        exp_t e;
        int   i;
        i = 0;
        while (!done && i < budget) begin
            @(negedge clk);
            i++;
        end
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        e = sbq.pop_front();
        chk({tag, "_code"}, 32'(err_code), 32'(e.code));
        chk({tag, "_addr"}, 32'(err_addr), 32'(e.addr));
        chk({tag, "_data"}, err_data, e.data);
        chk({tag, "_pass"}, 32'(pass), 32'(e.pass));
        chk({tag, "_nwr"}, 32'(n_wr - wr0), 32'(e.nwr));
        chk({tag, "_nrd"}, 32'(n_rd - rd0), 32'(e.nrd));
        @(negedge clk);
        chk({tag, "_done_off"}, 32'(done), 32'd0);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
        chk({tag, "_pass_hold"}, 32'(pass), 32'(e.pass));
    endtask

    initial begin
        int c0, h0, i;
        rst_n    = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        cfg_mode = 2'd0;
        cfg_base = 8'h0;
        cfg_last = 8'h0;
        cfg_pat  = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        chk("rst_code", 32'(err_code), 32'd0);
        chk("rst_cyc", 32'(cyc), 32'd0);
        chk("rst_stb", 32'(stb), 32'd0);
        chk("rst_sel", 32'(sel), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Full fill then verify.
        start_run(2'd3, 8'h00, 8'hFF, 32'hA5A5_0000,
                  '{ERR_NONE, 8'h00, 32'h0, 1'b1, 256, 256});
        finish_run("full", 3000);
        chk("mem3c", mem[8'h3C], 32'hA5A5_003C);

        // Verify with a corrupted word.
        bad_en = 1'b1;
        start_run(2'd2, 8'h00, 8'h1F, 32'hA5A5_0000,
                  '{ERR_MISMATCH, 8'h10, 32'h0, 1'b0, 0, 17});
        finish_run("mism", 500);
        bad_en = 1'b0;

        // Responder never acks address 5.
        hang_en = 1'b1;
        h0 = n_hang;
        start_run(2'd1, 8'h00, 8'h0F, 32'hA5A5_0000,
                  '{ERR_TIMEOUT, 8'h05, 32'h0, 1'b0, 5, 0});
        finish_run("tmo", 500);
        chk("tmo_cyc_len", 32'(n_hang - h0), 32'd16);
        hang_en = 1'b0;

        // Abort on the read of 0x40.
        start_run(2'd2, 8'h30, 8'h50, 32'hA5A5_0000,
                  '{ERR_ABORT, 8'h40, 32'h0, 1'b0, 0, 16});
        i = 0;
        while (!(cyc && !we && adr == 8'h40) && i < 500) begin
            @(negedge clk);
            i++;
        end
        chk("abt_reached", 32'(cyc), 32'd1);
        abort = 1'b1;
        @(negedge clk);
        chk("abt_cyc_low", 32'(cyc), 32'd0);
        chk("abt_stb_low", 32'(stb), 32'd0);
        abort = 1'b0;
        finish_run("abt", 50);
        c0 = n_cyc;
        repeat (10) @(negedge clk);
        chk("abt_quiet", 32'(n_cyc - c0), 32'd0);

        // Inverted range: no bus activity.
        c0 = n_cyc;
        start_run(2'd3, 8'h20, 8'h1F, 32'hA5A5_0000,
                  '{ERR_ABORT, 8'h20, 32'h0, 1'b0, 0, 0});
        finish_run("rng", 20);
        chk("rng_no_bus", 32'(n_cyc - c0), 32'd0);

        // Mode 00 is a passing no-op.
        c0 = n_cyc;
        start_run(2'd0, 8'h00, 8'h0F, 32'h0,
                  '{ERR_NONE, 8'h00, 32'h0, 1'b1, 0, 0});
        finish_run("nop", 20);
        chk("nop_no_bus", 32'(n_cyc - c0), 32'd0);

        // Single address at 0x7F.
        start_run(2'd1, 8'h7F, 8'h7F, 32'h1234_0000,
                  '{ERR_NONE, 8'h00, 32'h0, 1'b1, 1, 0});
        finish_run("one", 50);
        chk("mem7f", mem[8'h7F], 32'h1234_007F);

        // A second start while busy must not disturb the run.
        start_run(2'd1, 8'h00, 8'h3F, 32'hA5A5_0000,
                  '{ERR_NONE, 8'h00, 32'h0, 1'b1, 64, 0});
        repeat (5) @(negedge clk);
        cfg_mode = 2'd2;
        cfg_base = 8'h80;
        cfg_last = 8'h90;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        finish_run("busy", 1000);

        // Reset in the middle of a transfer.
        cfg_mode = 2'd3;
        cfg_base = 8'h00;
        cfg_last = 8'hFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        i = 0;
        while (!cyc && i < 20) begin
            @(negedge clk);
            i++;
        end
        chk("rstx_cyc_seen", 32'(cyc), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstx_cyc", 32'(cyc), 32'd0);
        chk("rstx_stb", 32'(stb), 32'd0);
        chk("rstx_we", 32'(we), 32'd0);
        chk("rstx_sel", 32'(sel), 32'd0);
        chk("rstx_adr", 32'(adr), 32'd0);
        chk("rstx_dat", dat_w, 32'd0);
        chk("rstx_busy", 32'(busy), 32'd0);
        chk("rstx_done", 32'(done), 32'd0);
        chk("rstx_pass", 32'(pass), 32'd0);
        chk("rstx_code", 32'(err_code), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("sb_empty", 32'(sbq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
